// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants and channel alignment state encoding
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    SLIPWAIT = 2'd1,
    ALIGNED  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/tmds_decode_chan.sv
// rtl/tmds_decode_chan.sv - one TMDS lane: token classify, data decode, word-alignment FSM
module tmds_decode_chan
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN  = 8,
  parameter int WINDOW    = 2048,
  parameter int SLIP_WAIT = 16
) (
  input  logic             clk_pix,
  input  logic             rst_n_pix,
  input  logic [SYM_W-1:0] sym,
  output logic             bitslip,
  output logic             aligned,
  output logic             is_ctrl,
  output logic [1:0]       ctrl,
  output logic [7:0]       data
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int SW_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  logic             tok_hit;
  logic [1:0]       tok_val;
  logic [7:0]       d;
  logic [7:0]       dec;

  chan_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic             slip_d;
  logic             hit, expire;

  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    dec     = '0;
    case (sym)
      CTRL_00: tok_val = 2'b00;
      CTRL_01: tok_val = 2'b01;
      CTRL_10: tok_val = 2'b10;
      CTRL_11: tok_val = 2'b11;
      default: tok_hit = 1'b0;
    endcase
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      is_ctrl <= 1'b0;
      ctrl    <= 2'b00;
      data    <= 8'h00;
    end else begin
      is_ctrl <= tok_hit;
      ctrl    <= tok_val;
      data    <= dec;
    end
  end

  // A saturated run keeps confirming alignment on every further control token.
  always_comb begin
    run_inc = tok_hit ? ((run_q == RUN_W'(CTRL_RUN)) ? run_q : run_q + RUN_W'(1)) : '0;
    hit     = (run_inc == RUN_W'(CTRL_RUN));
    expire  = (win_q == WIN_W'(WINDOW - 1));
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    sw_d    = sw_q;
    slip_d  = 1'b0;
    case (state_q)
      SEARCH, ALIGNED: begin
        run_d = run_inc;
        if (hit) begin
          win_d   = '0;
          state_d = ALIGNED;
        end else if (expire) begin
          win_d = '0;
          if (state_q == SEARCH) begin
            state_d = SLIPWAIT;
            sw_d    = '0;
            run_d   = '0;
            slip_d  = 1'b1;
          end else begin
            state_d = SEARCH;
          end
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      SLIPWAIT: begin
        if (sw_q == SW_W'(SLIP_WAIT - 1)) begin
          state_d = SEARCH;
          run_d   = '0;
          win_d   = '0;
        end else begin
          sw_d = sw_q + SW_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      state_q <= SEARCH;
      run_q   <= '0;
      win_q   <= '0;
      sw_q    <= '0;
      bitslip <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      sw_q    <= sw_d;
      bitslip <= slip_d;
    end
  end

  assign aligned = (state_q == ALIGNED);

endmodule

// File: rtl/tmds_rx_decode.sv
// rtl/tmds_rx_decode.sv - three-lane TMDS receiver: lock combine, pixel/sync outputs, X/Y position
module tmds_rx_decode
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN  = 8,
  parameter int WINDOW    = 2048,
  parameter int SLIP_WAIT = 16
) (
  input  logic             clk_pix,
  input  logic             rst_n_pix,
  input  logic [SYM_W-1:0] sym_d0,
  input  logic [SYM_W-1:0] sym_d1,
  input  logic [SYM_W-1:0] sym_d2,
  output logic [2:0]       bitslip,
  output logic             locked,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             frame_start
);

  logic [2:0] ch_aligned;
  logic [2:0] ch_is_ctrl;
  logic [1:0] ch_ctrl [3];
  logic [7:0] ch_data [3];
  logic       lock_all, de_n, hs_n, vs_n;
  logic       unused_ctrl;

  tmds_decode_chan #(.CTRL_RUN(CTRL_RUN), .WINDOW(WINDOW), .SLIP_WAIT(SLIP_WAIT)) u_chan0 (
    .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .sym(sym_d0), .bitslip(bitslip[0]),
    .aligned(ch_aligned[0]), .is_ctrl(ch_is_ctrl[0]), .ctrl(ch_ctrl[0]), .data(ch_data[0])
  );

  tmds_decode_chan #(.CTRL_RUN(CTRL_RUN), .WINDOW(WINDOW), .SLIP_WAIT(SLIP_WAIT)) u_chan1 (
    .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .sym(sym_d1), .bitslip(bitslip[1]),
    .aligned(ch_aligned[1]), .is_ctrl(ch_is_ctrl[1]), .ctrl(ch_ctrl[1]), .data(ch_data[1])
  );

  tmds_decode_chan #(.CTRL_RUN(CTRL_RUN), .WINDOW(WINDOW), .SLIP_WAIT(SLIP_WAIT)) u_chan2 (
    .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .sym(sym_d2), .bitslip(bitslip[2]),
    .aligned(ch_aligned[2]), .is_ctrl(ch_is_ctrl[2]), .ctrl(ch_ctrl[2]), .data(ch_data[2])
  );

  // Lanes 1/2 only carry pixel data here; their control codes are not interpreted.
  assign unused_ctrl = ^{ch_ctrl[1], ch_ctrl[2], ch_is_ctrl[2:1]};

  assign lock_all = &ch_aligned;
  assign de_n     = lock_all & ~ch_is_ctrl[0];
  assign hs_n     = ch_is_ctrl[0] ? ch_ctrl[0][0] : hsync;
  assign vs_n     = ch_is_ctrl[0] ? ch_ctrl[0][1] : vsync;

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      locked      <= 1'b0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      r           <= 8'h00;
      g           <= 8'h00;
      b           <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      locked      <= lock_all;
      de          <= de_n;
      hsync       <= hs_n;
      vsync       <= vs_n;
      frame_start <= lock_all & vs_n & ~vsync;
      if (!lock_all) begin
        r <= 8'h00;
        g <= 8'h00;
        b <= 8'h00;
      end else if (de_n) begin
        r <= ch_data[2];
        g <= ch_data[1];
        b <= ch_data[0];
      end
    end
  end

  // x is the index of the pixel currently presented; it stays one past the
  // last pixel for the first blank cycle and then returns to 0.
  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (!lock_all) begin
      x <= 10'd0;
      y <= 10'd0;
    end else begin
      x <= de ? x + 10'd1 : 10'd0;
      if (vs_n & ~vsync) begin
        y <= 10'd0;
      end else if (de & ~de_n) begin
        y <= y + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_decode.sv
// tb/tb_tmds_rx_decode.sv - directed self-checking bench for tmds_rx_decode
module tb_tmds_rx_decode;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam int WINDOW    = 2048;
  localparam int SLIP_WAIT = 16;
  localparam int CTRL_RUN  = 8;
  localparam int H_ACT = 20, H_TOT = 32, V_ACT = 6, V_TOT = 9;

  logic       clk_pix = 1'b0;
  logic       rst_n_pix = 1'b0;
  logic [9:0] sym_d0 = T00, sym_d1 = T00, sym_d2 = T00;
  logic [2:0] bitslip;
  logic       locked, de, hsync, vsync, frame_start;
  logic [7:0] r, g, b;
  logic [9:0] x, y;

  int total = 0;
  int bad = 0;
  int disp [3];
  logic [26:0] e_vec [0:700];
  logic [9:0]  e_x [0:700];
  logic [9:0]  e_y [0:700];
  logic [23:0] e_rt [0:255];
  logic [9:0]  dq [3] = '{10'h100, 10'h200, 10'h1FF};
  logic [7:0]  dv [3] = '{8'h00, 8'hFF, 8'h01};

  tmds_rx_decode dut (
    .clk_pix(clk_pix), .rst_n_pix(rst_n_pix),
    .sym_d0(sym_d0), .sym_d1(sym_d1), .sym_d2(sym_d2),
    .bitslip(bitslip), .locked(locked), .r(r), .g(g), .b(b),
    .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y), .frame_start(frame_start)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  function automatic logic [9:0] enc(input int ch, input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1m, n0m;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1m = $countones(qm[7:0]);
    n0m = 8 - n1m;
    if (disp[ch] == 0 || n1m == n0m) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp[ch] = qm[8] ? disp[ch] + n1m - n0m : disp[ch] + n0m - n1m;
    end else if ((disp[ch] > 0 && n1m > n0m) || (disp[ch] < 0 && n0m > n1m)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp[ch] = disp[ch] + (qm[8] ? 2 : 0) + n0m - n1m;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp[ch] = disp[ch] - (qm[8] ? 0 : 2) + n1m - n0m;
    end
    return q;
  endfunction

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00: return T00;
      2'b01: return T01;
      2'b10: return T10;
      default: return T11;
    endcase
  endfunction

  function automatic logic [9:0] pat(input int n);
    if ((n % 64) < 16) return T00;
    return (n % 2 == 1) ? 10'h1F0 : 10'h0C3;
  endfunction

  task automatic tick(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    @(posedge clk_pix);
    #1;
    sym_d0 = a0;
    sym_d1 = a1;
    sym_d2 = a2;
  endtask

  task automatic lock_up();
    repeat (12) tick(T00, T00, T00);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_up: locked=%b want 1", locked);
    end
  endtask

  task automatic test_reset();
    rst_n_pix = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    total++;
    if ({bitslip, locked, r, g, b, de, hsync, vsync, x, y, frame_start} !== 52'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {bitslip, locked, r, g, b, de, hsync, vsync, x, y, frame_start});
    end
    @(negedge clk_pix);
    rst_n_pix = 1'b1;
  endtask

  task automatic test_token_decode();
    logic [9:0] toks [4];
    toks = '{T00, T01, T10, T11};
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick(toks[k], T00, T00);
      total++;
      if ({vsync, hsync} !== 2'(k)) begin
        bad++;
        $display("FAIL token_sync[%0d]: got %b want %b", k, {vsync, hsync}, 2'(k));
      end
      total++;
      if (de !== 1'b0) begin
        bad++;
        $display("FAIL token_de[%0d]: got %b want 0", k, de);
      end
    end
  endtask

  task automatic test_data_decode();
    logic [7:0] v;
    logic [9:0] a0, a1, a2;
    lock_up();
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick(dq[k], dq[k], dq[k]);
      total++;
      if ({r, g, b, de} !== {dv[k], dv[k], dv[k], 1'b1}) begin
        bad++;
        $display("FAIL data_directed[%0d]: got r%h g%h b%h de%b want %h de1", k, r, g, b, de, dv[k]);
      end
    end
    disp = '{0, 0, 0};
    for (int n = 0; n < 258; n++) begin
      if (n < 256) begin
        v = 8'(n);
        a0 = enc(0, v);
        a1 = enc(1, v ^ 8'h5A);
        a2 = enc(2, ~v);
        e_rt[n] = {~v, v ^ 8'h5A, v};
      end else begin
        a0 = T00; a1 = T00; a2 = T00;
        disp = '{0, 0, 0};
      end
      tick(a0, a1, a2);
      if (n >= 2) begin
        total++;
        if ({r, g, b, de} !== {e_rt[n-2], 1'b1}) begin
          bad++;
          $display("FAIL data_roundtrip[%0d]: got %h%h%h de%b want %h de1", n - 2, r, g, b, de, e_rt[n-2]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int l, c, nt;
    logic act, hs, vs, hhs, hvs;
    logic [7:0] hr, hg, hb;
    logic [9:0] a0, a1, a2;
    nt = 2 * V_TOT * H_TOT;
    hr = 8'h00; hg = 8'hA5; hb = 8'hFF; hhs = 1'b0; hvs = 1'b0;
    for (int n = 0; n < nt + 2; n++) begin
      if (n < nt) begin
        l = (7 + n / H_TOT) % V_TOT;
        c = n % H_TOT;
        act = (l < V_ACT) && (c < H_ACT);
        hs = (c >= 24) && (c < 28);
        vs = (l == 7);
        if (act) begin
          a0 = enc(0, 8'd3);
          a1 = enc(1, 8'(l));
          a2 = enc(2, 8'(c));
          hr = 8'(c); hg = 8'(l); hb = 8'd3;
        end else begin
          a0 = tok({vs, hs});
          a1 = T00; a2 = T00;
          disp = '{0, 0, 0};
          hhs = hs; hvs = vs;
        end
        e_vec[n] = {hr, hg, hb, act, hhs, hvs};
        e_x[n] = 10'(c);
        e_y[n] = 10'(l);
      end else begin
        a0 = T00; a1 = T00; a2 = T00;
      end
      tick(a0, a1, a2);
      if (n >= 3) begin
        total++;
        if ({r, g, b, de, hsync, vsync} !== e_vec[n-2]) begin
          bad++;
          $display("FAIL loop_pixel[%0d]: got %h want %h", n - 2, {r, g, b, de, hsync, vsync}, e_vec[n-2]);
        end
        total++;
        if (frame_start !== (e_vec[n-2][0] & ~e_vec[n-3][0])) begin
          bad++;
          $display("FAIL loop_frame_start[%0d]: got %b want %b", n - 2, frame_start, e_vec[n-2][0] & ~e_vec[n-3][0]);
        end
        if (e_vec[n-2][2]) begin
          total++;
          if ({x, y} !== {e_x[n-2], e_y[n-2]}) begin
            bad++;
            $display("FAIL loop_xy[%0d]: got x%0d y%0d want x%0d y%0d", n - 2, x, y, e_x[n-2], e_y[n-2]);
          end
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int k;
    logic slip_seen;
    lock_up();
    slip_seen = 1'b0;
    k = 0;
    while (k < WINDOW + 10 && locked === 1'b1) begin
      tick(10'h1F0, 10'h1F0, 10'h1F0);
      k++;
      if (bitslip !== 3'b000) slip_seen = 1'b1;
    end
    total++;
    if (k < WINDOW || k > WINDOW + 3 || locked !== 1'b0) begin
      bad++;
      $display("FAIL lock_loss_time: locked=%b after %0d cycles want 0 after %0d..%0d", locked, k, WINDOW, WINDOW + 3);
    end
    total++;
    if ({de, x, y} !== 21'd0) begin
      bad++;
      $display("FAIL lock_loss_outputs: got de%b x%0d y%0d want 0", de, x, y);
    end
    total++;
    if (slip_seen !== 1'b0) begin
      bad++;
      $display("FAIL lock_loss_slip: got slip pulse want none");
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    lock_up();
    k = 0;
    while (k < 200 && x !== 10'd100) begin
      tick(10'h1F0, 10'h0C3, 10'h1F0);
      k++;
    end
    total++;
    if (x !== 10'd100) begin
      bad++;
      $display("FAIL midframe_x: got %0d want 100", x);
    end
    #2;
    rst_n_pix = 1'b0;
    #1;
    total++;
    if ({bitslip, locked, r, g, b, de, hsync, vsync, x, y, frame_start} !== 52'd0) begin
      bad++;
      $display("FAIL midframe_async_reset: got %h want 0",
               {bitslip, locked, r, g, b, de, hsync, vsync, x, y, frame_start});
    end
    sym_d0 = T00; sym_d1 = T00; sym_d2 = T00;
    @(negedge clk_pix);
    rst_n_pix = 1'b1;
    k = 0;
    while (k < CTRL_RUN + 6 && locked !== 1'b1) begin
      tick(T00, T00, T00);
      k++;
    end
    total++;
    if (locked !== 1'b1 || k > CTRL_RUN + 2) begin
      bad++;
      $display("FAIL midframe_relock: locked=%b after %0d cycles want 1 within %0d", locked, k, CTRL_RUN + 2);
    end
  endtask

  task automatic test_misalign();
    int off, pulses, last, n;
    logic side;
    logic [19:0] w;
    rst_n_pix = 1'b0;
    @(negedge clk_pix);
    rst_n_pix = 1'b1;
    off = 3; pulses = 0; last = -1; side = 1'b0; n = 0;
    while (n < 20000 && locked !== 1'b1) begin
      w = {pat(n + 1), pat(n)} >> off;
      tick(pat(n), w[9:0], pat(n));
      if (bitslip[0] !== 1'b0 || bitslip[2] !== 1'b0) side = 1'b1;
      if (bitslip[1] === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          total++;
          if (n - last !== WINDOW + SLIP_WAIT) begin
            bad++;
            $display("FAIL slip_interval[%0d]: got %0d want %0d", pulses, n - last, WINDOW + SLIP_WAIT);
          end
        end
        last = n;
        off = (off + 1) % 10;
      end
      n++;
    end
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL misalign_lock: locked=%b want 1 after slips", locked);
    end
    total++;
    if (pulses !== 7) begin
      bad++;
      $display("FAIL misalign_pulses: got %0d want 7", pulses);
    end
    total++;
    if (side !== 1'b0) begin
      bad++;
      $display("FAIL misalign_other_lanes: got slip on lane 0/2 want none");
    end
  endtask

  initial begin
    disp = '{0, 0, 0};
    test_reset();
    test_token_decode();
    test_data_decode();
    test_loopback();
    test_lock_loss();
    test_reset_midframe();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
